// File: rtl/cmat_row_store.sv
// cmat_row_store: multi-bank, row-addressed, flip-flop store of complex SIZE x SIZE matrices.
// Elements are {imag, real}, each WIDTH bits; element k of a row sits at [k*2*WIDTH +: 2*WIDTH].
// Optional build macro: CMAT_STORE_CONJ_EN adds rd_conj_i / copy_conj_i, which invert each element's
// imaginary sign bit on the read output / copy path.
//
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   flush_i            abort copy, kill in-flight reads
//   rd_*_i             read request (row, or column when rd_transpose_i), no backpressure
//   rd_row_o/addr_o/valid_o  read response, READ_LATENCY cycles after the request
//   wr_*_i, wr_ready_o row write-back handshake (ready only while the copy engine is idle)
//   copy_*_i           start a bank-to-bank copy / transpose
//   copy_done_o        one-cycle pulse at copy completion
//   copy_err_o         one-cycle pulse when a copy is rejected (in-place transpose)
//   busy_o             copy engine is moving rows
module cmat_row_store #(
    parameter int unsigned SIZE         = 4,
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned NUM_BANKS    = 4,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         rd_valid_i,
    input  logic [$clog2(SIZE)-1:0]      rd_addr_i,
    input  logic [$clog2(NUM_BANKS)-1:0] rd_bank_i,
    input  logic                         rd_transpose_i,
`ifdef CMAT_STORE_CONJ_EN
    input  logic                         rd_conj_i,
`endif
    output logic [SIZE*2*WIDTH-1:0]      rd_row_o,
    output logic [$clog2(SIZE)-1:0]      rd_addr_o,
    output logic                         rd_valid_o,
    input  logic                         wr_valid_i,
    output logic                         wr_ready_o,
    input  logic [$clog2(SIZE)-1:0]      wr_addr_i,
    input  logic [$clog2(NUM_BANKS)-1:0] wr_bank_i,
    input  logic [SIZE*2*WIDTH-1:0]      wr_row_i,
    input  logic                         copy_start_i,
    input  logic [$clog2(NUM_BANKS)-1:0] copy_src_bank_i,
    input  logic [$clog2(NUM_BANKS)-1:0] copy_dst_bank_i,
    input  logic                         copy_transpose_i,
`ifdef CMAT_STORE_CONJ_EN
    input  logic                         copy_conj_i,
`endif
    output logic                         copy_done_o,
    output logic                         copy_err_o,
    output logic                         busy_o
);

    localparam int unsigned AW = $clog2(SIZE);
    localparam int unsigned BW = $clog2(NUM_BANKS);
    localparam int unsigned EW = 2 * WIDTH;
    localparam int unsigned RW = SIZE * EW;
    localparam int unsigned PL = READ_LATENCY;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Storage
    logic [EW-1:0] mem [NUM_BANKS][SIZE][SIZE];

    // Copy engine state
    state_t        state, state_next;
    logic [AW-1:0] copy_row;
    logic [BW-1:0] copy_src, copy_dst;
    logic          copy_tr;
`ifdef CMAT_STORE_CONJ_EN
    logic          copy_cj;
`endif
    logic          start_ok, start_err;
    logic [RW-1:0] copy_data;

    // Read path
    logic [RW-1:0] rd_data;
    logic [PL-1:0] pipe_valid;
    logic [RW-1:0] pipe_data [PL];
    logic [AW-1:0] pipe_addr [PL];

    // Range checks matter only for non-power-of-two SIZE / NUM_BANKS
    logic rd_in_range, wr_in_range, copy_in_range;
    assign rd_in_range   = (32'(rd_addr_i) < SIZE) && (32'(rd_bank_i) < NUM_BANKS);
    assign wr_in_range   = (32'(wr_addr_i) < SIZE) && (32'(wr_bank_i) < NUM_BANKS);
    assign copy_in_range = (32'(copy_src_bank_i) < NUM_BANKS) && (32'(copy_dst_bank_i) < NUM_BANKS);

    // Read data sampled from storage in the accept cycle (old data on same-cycle write)
    always_comb begin
        rd_data = '0;
        if (rd_in_range) begin
            for (int k = 0; k < int'(SIZE); k++) begin
                rd_data[k*EW +: EW] = rd_transpose_i ? mem[rd_bank_i][k][rd_addr_i]
                                                     : mem[rd_bank_i][rd_addr_i][k];
`ifdef CMAT_STORE_CONJ_EN
                rd_data[k*EW + EW - 1] = rd_data[k*EW + EW - 1] ^ rd_conj_i;
`endif
            end
        end
    end

    // Row (or column) currently moved by the copy engine
    always_comb begin
        copy_data = '0;
        for (int k = 0; k < int'(SIZE); k++) begin
            copy_data[k*EW +: EW] = copy_tr ? mem[copy_src][k][copy_row]
                                            : mem[copy_src][copy_row][k];
`ifdef CMAT_STORE_CONJ_EN
            copy_data[k*EW + EW - 1] = copy_data[k*EW + EW - 1] ^ copy_cj;
`endif
        end
    end

    // Copy FSM next state; flush overrides everything
    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        start_err  = 1'b0;
        unique case (state)
            IDLE: begin
                if (copy_start_i && copy_in_range) begin
                    if ((copy_src_bank_i == copy_dst_bank_i) && copy_transpose_i) begin
                        start_err = 1'b1;
                    end else begin
                        start_ok   = 1'b1;
                        state_next = COPY;
                    end
                end
            end
            COPY: begin
                if (copy_row == AW'(SIZE - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (flush_i) begin
            state_next = IDLE;
            start_ok   = 1'b0;
            start_err  = 1'b0;
        end
    end

    // Copy FSM state register and registered status outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= IDLE;
            copy_row    <= '0;
            copy_src    <= '0;
            copy_dst    <= '0;
            copy_tr     <= 1'b0;
`ifdef CMAT_STORE_CONJ_EN
            copy_cj     <= 1'b0;
`endif
            busy_o      <= 1'b0;
            copy_done_o <= 1'b0;
            copy_err_o  <= 1'b0;
            wr_ready_o  <= 1'b0;
        end else begin
            state       <= state_next;
            busy_o      <= (state_next == COPY);
            copy_done_o <= (state_next == DONE);
            copy_err_o  <= start_err;
            wr_ready_o  <= (state_next == IDLE);
            if (start_ok) begin
                copy_row <= '0;
                copy_src <= copy_src_bank_i;
                copy_dst <= copy_dst_bank_i;
                copy_tr  <= copy_transpose_i;
`ifdef CMAT_STORE_CONJ_EN
                copy_cj  <= copy_conj_i;
`endif
            end else if (state == COPY) begin
                copy_row <= copy_row + AW'(1);
            end
        end
    end

    // Storage update: user write (idle only) and copy row write never coincide
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                for (int r = 0; r < int'(SIZE); r++) begin
                    for (int c = 0; c < int'(SIZE); c++) begin
                        mem[b][r][c] <= '0;
                    end
                end
            end
        end else begin
            if (wr_valid_i && wr_ready_o && wr_in_range) begin
                for (int c = 0; c < int'(SIZE); c++) begin
                    mem[wr_bank_i][wr_addr_i][c] <= wr_row_i[c*EW +: EW];
                end
            end
            if (state == COPY) begin
                for (int c = 0; c < int'(SIZE); c++) begin
                    mem[copy_dst][copy_row][c] <= copy_data[c*EW +: EW];
                end
            end
        end
    end

    // Read pipeline; flush drops the incoming request and kills every stage
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pipe_valid <= '0;
            for (int s = 0; s < int'(PL); s++) begin
                pipe_data[s] <= '0;
                pipe_addr[s] <= '0;
            end
        end else begin
            pipe_valid[0] <= rd_valid_i && !flush_i;
            if (rd_valid_i && !flush_i) begin
                pipe_data[0] <= rd_data;
                pipe_addr[0] <= rd_addr_i;
            end
            for (int s = 1; s < int'(PL); s++) begin
                pipe_valid[s] <= pipe_valid[s-1] && !flush_i;
                if (pipe_valid[s-1] && !flush_i) begin
                    pipe_data[s] <= pipe_data[s-1];
                    pipe_addr[s] <= pipe_addr[s-1];
                end
            end
        end
    end

    assign rd_valid_o = pipe_valid[PL-1];
    assign rd_row_o   = pipe_data[PL-1];
    assign rd_addr_o  = pipe_addr[PL-1];

endmodule

// File: tb/tb_cmat_row_store.sv
// Self-checking bench for cmat_row_store (SIZE=4, WIDTH=64, NUM_BANKS=4, READ_LATENCY=2).
// A matrix-level model tracks bank contents, pending read responses and copy progress.
module tb_cmat_row_store;

    localparam int SIZE = 4;
    localparam int WIDTH = 64;
    localparam int NB = 4;
    localparam int L = 2;
    localparam int EW = 2 * WIDTH;
    localparam int RW = SIZE * EW;
`ifdef CMAT_STORE_CONJ_EN
    localparam bit CONJ = 1'b1;
`else
    localparam bit CONJ = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, flush;
    logic          rd_valid, rd_tr, rd_conj;
    logic [1:0]    rd_addr, rd_bank;
    logic [RW-1:0] rd_row_o;
    logic [1:0]    rd_addr_o;
    logic          rd_valid_o;
    logic          wr_valid, wr_ready;
    logic [1:0]    wr_addr, wr_bank;
    logic [RW-1:0] wr_row;
    logic          copy_start, copy_tr, copy_conj;
    logic [1:0]    copy_src, copy_dst;
    logic          copy_done, copy_err, busy;

    cmat_row_store #(
        .SIZE(SIZE), .WIDTH(WIDTH), .NUM_BANKS(NB), .READ_LATENCY(L)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .rd_valid_i(rd_valid), .rd_addr_i(rd_addr), .rd_bank_i(rd_bank),
        .rd_transpose_i(rd_tr),
`ifdef CMAT_STORE_CONJ_EN
        .rd_conj_i(rd_conj),
`endif
        .rd_row_o(rd_row_o), .rd_addr_o(rd_addr_o), .rd_valid_o(rd_valid_o),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr),
        .wr_bank_i(wr_bank), .wr_row_i(wr_row),
        .copy_start_i(copy_start), .copy_src_bank_i(copy_src), .copy_dst_bank_i(copy_dst),
        .copy_transpose_i(copy_tr),
`ifdef CMAT_STORE_CONJ_EN
        .copy_conj_i(copy_conj),
`endif
        .copy_done_o(copy_done), .copy_err_o(copy_err), .busy_o(busy)
    );

    // Reference model
    typedef struct {
        int            due;
        logic [RW-1:0] row;
        logic [1:0]    addr;
    } rd_t;

    logic [EW-1:0] m [NB][SIZE][SIZE];
    rd_t           pend[$];
    logic [RW-1:0] cap[$];
    int            cap_cyc[$];
    int            cyc = 0;
    int            vectors = 0;
    int            errors = 0;
    bit            m_ready = 1'b0;
    int            m_phase = 0;   // 0 idle, 1 copying, 2 done pulse
    int            m_row = 0, m_src = 0, m_dst = 0;
    bit            m_tr = 1'b0, m_cj = 1'b0;

    function automatic logic [RW-1:0] m_read(int b, int a, bit tr, bit cj);
        logic [RW-1:0] v;
        for (int k = 0; k < SIZE; k++) begin
            v[k*EW +: EW] = tr ? m[b][k][a] : m[b][a][k];
            if (cj) v[k*EW + EW - 1] = ~v[k*EW + EW - 1];
        end
        return v;
    endfunction

    function automatic logic [EW-1:0] cplx(real re, real im);
        return {$realtobits(im), $realtobits(re)};
    endfunction

    function automatic logic [EW-1:0] elem(logic [RW-1:0] row, int k);
        return row[k*EW +: EW];
    endfunction

    task automatic chk(string tag, logic [RW-1:0] got, logic [RW-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        flush = 0; rd_valid = 0; rd_tr = 0; rd_conj = 0; rd_addr = 0; rd_bank = 0;
        wr_valid = 0; wr_addr = 0; wr_bank = 0; wr_row = '0;
        copy_start = 0; copy_tr = 0; copy_conj = 0; copy_src = 0; copy_dst = 0;
    endtask

    // One clock: advance the model on current inputs, clock the DUT, check all outputs
    task automatic tick();
        bit            e_err;
        bit            exp_v;
        rd_t           t;
        logic [RW-1:0] cr;
        e_err = 1'b0;
        if (!rst_n) begin
            for (int b = 0; b < NB; b++)
                for (int r = 0; r < SIZE; r++)
                    for (int c = 0; c < SIZE; c++) m[b][r][c] = '0;
            pend.delete();
            m_phase = 0;
        end else begin
            if (flush) pend.delete();
            else if (rd_valid) begin
                t.due  = cyc + L;
                t.row  = m_read(int'(rd_bank), int'(rd_addr), rd_tr, rd_conj & CONJ);
                t.addr = rd_addr;
                pend.push_back(t);
            end
            if (m_phase == 1) begin
                cr = m_read(m_src, m_row, m_tr, m_cj);
                for (int c = 0; c < SIZE; c++) m[m_dst][m_row][c] = cr[c*EW +: EW];
            end
            if (wr_valid && m_ready)
                for (int c = 0; c < SIZE; c++) m[wr_bank][wr_addr][c] = wr_row[c*EW +: EW];
            if (flush) m_phase = 0;
            else if (m_phase == 1) begin
                m_row++;
                if (m_row == SIZE) m_phase = 2;
            end else if (m_phase == 2) m_phase = 0;
            else if (copy_start) begin
                if (copy_src == copy_dst && copy_tr) e_err = 1'b1;
                else begin
                    m_phase = 1; m_row = 0; m_src = int'(copy_src); m_dst = int'(copy_dst);
                    m_tr = copy_tr; m_cj = copy_conj & CONJ;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        m_ready = rst_n && (m_phase == 0);
        chk("wr_ready", RW'(wr_ready), RW'(m_ready));
        chk("busy", RW'(busy), RW'(m_phase == 1));
        chk("copy_done", RW'(copy_done), RW'(m_phase == 2));
        chk("copy_err", RW'(copy_err), RW'(e_err));
        exp_v = (pend.size() > 0) && (pend[0].due == cyc);
        chk("rd_valid", RW'(rd_valid_o), RW'(exp_v));
        if (exp_v) begin
            chk("rd_row", rd_row_o, pend[0].row);
            chk("rd_addr", RW'(rd_addr_o), RW'(pend[0].addr));
            void'(pend.pop_front());
        end
        if (rd_valid_o === 1'b1) begin
            cap.push_back(rd_row_o);
            cap_cyc.push_back(cyc);
        end
    endtask

    task automatic do_read(int b, int a, bit tr);
        rd_valid = 1; rd_bank = 2'(b); rd_addr = 2'(a); rd_tr = tr;
        tick();
        rd_valid = 0; rd_tr = 0;
    endtask

    task automatic do_write(int b, int a, logic [RW-1:0] row);
        wr_valid = 1; wr_bank = 2'(b); wr_addr = 2'(a); wr_row = row;
        tick();
        wr_valid = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < L + 1; i++) tick();
    endtask

    initial begin
        logic [RW-1:0] row;
        logic [RW-1:0] exp;
        int            c0;
        int            busy_cnt, done_cnt, rdy_busy;

        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) tick();
        chk("reset_rd_row", rd_row_o, '0);
        chk("reset_rd_addr", RW'(rd_addr_o), '0);
        rst_n = 1;
        tick();

        // Single element write, read with latency 2
        row = '0;
        row[2*EW +: EW] = cplx(-1.5, 3.0);
        do_write(0, 1, row);
        cap.delete(); cap_cyc.delete();
        c0 = cyc;
        do_read(0, 1, 0);
        drain();
        chk("t1_count", RW'(cap.size()), RW'(1));
        if (cap.size() > 0) begin
            exp = '0;
            exp[2*EW +: EW] = {64'h4008000000000000, 64'hBFF8000000000000};
            chk("t1_row", cap[0], exp);
            chk("t1_latency", RW'(cap_cyc[0]), RW'(c0 + 2));
        end

        // Bank1 element (r,c) real = 10r+c; transposed read of column 2
        for (int r = 0; r < SIZE; r++) begin
            row = '0;
            for (int c = 0; c < SIZE; c++) row[c*EW +: EW] = cplx(real'(10 * r + c), 0.0);
            do_write(1, r, row);
        end
        cap.delete(); cap_cyc.delete();
        do_read(1, 2, 1);
        drain();
        chk("t2_count", RW'(cap.size()), RW'(1));
        if (cap.size() > 0)
            for (int k = 0; k < SIZE; k++)
                chk($sformatf("t2_elem%0d", k), RW'(elem(cap[0], k)), RW'(cplx(real'(10 * k + 2), 0.0)));

        // Transposing copy bank1 -> bank2
        copy_start = 1; copy_src = 1; copy_dst = 2; copy_tr = 1;
        busy_cnt = 0; done_cnt = 0; rdy_busy = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            copy_start = 0; copy_tr = 0;
            if (busy === 1'b1) busy_cnt++;
            if (copy_done === 1'b1) done_cnt++;
            if (busy === 1'b1 && wr_ready === 1'b1) rdy_busy++;
        end
        chk("t3_busy_cycles", RW'(busy_cnt), RW'(4));
        chk("t3_done_pulses", RW'(done_cnt), RW'(1));
        chk("t3_ready_in_copy", RW'(rdy_busy), RW'(0));
        cap.delete(); cap_cyc.delete();
        for (int r = 0; r < SIZE; r++) do_read(2, r, 0);
        drain();
        chk("t3_count", RW'(cap.size()), RW'(SIZE));
        if (cap.size() == SIZE)
            for (int i = 0; i < SIZE; i++)
                for (int j = 0; j < SIZE; j++)
                    chk($sformatf("t3_b2_%0d_%0d", i, j), RW'(elem(cap[i], j)),
                        RW'(cplx(real'(10 * j + i), 0.0)));

        // In-place transpose rejected
        copy_start = 1; copy_src = 3; copy_dst = 3; copy_tr = 1;
        tick();
        copy_start = 0; copy_tr = 0;
        chk("t4_err", RW'(copy_err), RW'(1));
        chk("t4_busy", RW'(busy), RW'(0));
        tick();
        chk("t4_err_pulse", RW'(copy_err), RW'(0));

        // Flush on the 2nd copy cycle with reads in flight
        copy_start = 1; copy_src = 1; copy_dst = 3; copy_tr = 0;
        tick();
        copy_start = 0;
        do_read(1, 0, 0);
        flush = 1;
        do_read(1, 1, 0);
        flush = 0;
        chk("t5_valid_a", RW'(rd_valid_o), RW'(0));
        chk("t5_busy", RW'(busy), RW'(0));
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) chk("t5_valid_b", RW'(rd_valid_o), RW'(0));
            tick();
            if (copy_done === 1'b1) done_cnt++;
        end
        chk("t5_no_done", RW'(done_cnt), RW'(0));
        cap.delete(); cap_cyc.delete();
        for (int r = 0; r < SIZE; r++) do_read(3, r, 0);
        drain();
        if (cap.size() == SIZE)
            for (int r = 0; r < SIZE; r++)
                chk($sformatf("t5_b3_r%0d_e1", r), RW'(elem(cap[r], 1)),
                    RW'((r < 2) ? cplx(real'(10 * r + 1), 0.0) : '0));
        else chk("t5_count", RW'(cap.size()), RW'(SIZE));

        // Read-before-write on bank0 row0
        row = '0; row[0 +: EW] = cplx(5.0, 0.0);
        do_write(0, 0, row);
        cap.delete(); cap_cyc.delete();
        row[0 +: EW] = cplx(7.0, 0.0);
        wr_valid = 1; wr_bank = 0; wr_addr = 0; wr_row = row;
        do_read(0, 0, 0);
        wr_valid = 0;
        do_read(0, 0, 0);
        drain();
        if (cap.size() == 2) begin
            chk("t6_old", RW'(elem(cap[0], 0)), RW'(cplx(5.0, 0.0)));
            chk("t6_new", RW'(elem(cap[1], 0)), RW'(cplx(7.0, 0.0)));
        end else chk("t6_count", RW'(cap.size()), RW'(2));
`ifdef CMAT_STORE_CONJ_EN
        row = '0; row[0 +: EW] = cplx(1.0, 2.0);
        do_write(0, 2, row);
        cap.delete(); cap_cyc.delete();
        rd_conj = 1;
        do_read(0, 2, 0);
        rd_conj = 0;
        drain();
        if (cap.size() == 1) chk("t6_conj", RW'(elem(cap[0], 0)), RW'(cplx(1.0, -2.0)));
        else chk("t6_conj_count", RW'(cap.size()), RW'(1));
`endif

        // Reset mid-copy: copy abandoned, storage cleared
        copy_start = 1; copy_src = 1; copy_dst = 2; copy_tr = 0;
        tick();
        copy_start = 0;
        tick();
        rst_n = 0;
        tick();
        chk("t7_busy", RW'(busy), RW'(0));
        chk("t7_ready", RW'(wr_ready), RW'(0));
        rst_n = 1;
        tick();
        cap.delete(); cap_cyc.delete();
        do_read(1, 0, 0);
        drain();
        if (cap.size() == 1) chk("t7_cleared", cap[0], '0);
        else chk("t7_count", RW'(cap.size()), RW'(1));

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rd_valid = 1'($urandom_range(0, 1));
            rd_bank  = 2'($urandom_range(0, 3));
            rd_addr  = 2'($urandom_range(0, 3));
            rd_tr    = 1'($urandom_range(0, 1));
            rd_conj  = 1'($urandom_range(0, 1));
            wr_valid = 1'($urandom_range(0, 1));
            wr_bank  = 2'($urandom_range(0, 3));
            wr_addr  = 2'($urandom_range(0, 3));
            for (int i = 0; i < RW / 32; i++) wr_row[i*32 +: 32] = $urandom;
            copy_start = ($urandom_range(0, 15) == 0);
            copy_src   = 2'($urandom_range(0, 3));
            copy_dst   = 2'($urandom_range(0, 3));
            copy_tr    = 1'($urandom_range(0, 1));
            copy_conj  = 1'($urandom_range(0, 1));
            flush      = ($urandom_range(0, 31) == 0);
            tick();
        end
        idle_inputs();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cmat_row_store.md
Name: cmat_row_store

Overview:
- Multi-bank, row-addressed store for complex SIZE x SIZE matrices.
- Serves the row read-address/valid handshake used by lu and triang_matrix_inv, and accepts their row write-back.
- Adds transposed reads and a sequenced bank-to-bank copy/transpose engine, so matrix staging between LU, inversion and multiply stages runs in hardware.
- Storage is flip-flop based; one element = {imag, real}, each WIDTH-bit IEEE-754.

Parameters:
- SIZE, 4, matrix dimension; must be >= 2.
- WIDTH, 64, bits per real or imaginary part.
- NUM_BANKS, 4, number of independent matrices held; must be >= 2.
- READ_LATENCY, 1, read pipeline depth; legal values 1..3.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- flush_i  in  1  abort copy, kill in-flight reads
- rd_valid_i  in  1  read request
- rd_addr_i  in  $clog2(SIZE)  row index (column index when transposed)
- rd_bank_i  in  $clog2(NUM_BANKS)  bank select
- rd_transpose_i  in  1  return column rd_addr_i instead of row
- rd_row_o  out  SIZE*2*WIDTH  read data; element k at [k*2*WIDTH +: 2*WIDTH], real in low half
- rd_addr_o  out  $clog2(SIZE)  address echo aligned with rd_row_o
- rd_valid_o  out  1  read data valid
- wr_valid_i  in  1  write request
- wr_ready_o  out  1  write accepted when high
- wr_addr_i  in  $clog2(SIZE)  row to write
- wr_bank_i  in  $clog2(NUM_BANKS)  bank to write
- wr_row_i  in  SIZE*2*WIDTH  write data
- copy_start_i  in  1  start copy engine
- copy_src_bank_i  in  $clog2(NUM_BANKS)  source bank
- copy_dst_bank_i  in  $clog2(NUM_BANKS)  destination bank
- copy_transpose_i  in  1  dst = transpose(src)
- copy_done_o  out  1  one-cycle pulse when a copy completes
- copy_err_o  out  1  one-cycle pulse when a copy is rejected
- busy_o  out  1  copy engine active

Behaviour:
- Reset (rst_ni=0 at a clk_i edge): all banks cleared to 0; FSM to IDLE; rd_valid_o, copy_done_o, copy_err_o, busy_o = 0; rd_row_o, rd_addr_o = 0; wr_ready_o = 0 while reset is held. Reset mid-copy abandons the copy with no done pulse.
- Read: request accepted every cycle with no backpressure.
  - Data is sampled from storage in the accept cycle.
  - rd_valid_o/rd_row_o/rd_addr_o appear exactly READ_LATENCY cycles later.
  - Back-to-back requests give back-to-back outputs.
  - Transposed read: element k = bank[rd_bank_i][k][rd_addr_i].
  - Read and write to the same row in one cycle: read returns old data (read-before-write).
- Write: committed at the clock edge when wr_valid_i && wr_ready_o. wr_ready_o = 1 in IDLE, 0 in COPY.
- Copy FSM:
  - IDLE: copy_start_i with src==dst && copy_transpose_i -> copy_err_o pulse next cycle, stay IDLE, no storage change. Otherwise latch src/dst/transpose, go to COPY with r=0, busy_o=1.
  - A write accepted in the same cycle as copy_start_i is committed before the copy reads it.
  - COPY: each cycle, dst row r <= src row r (or src column r when transposed); r increments. After r=SIZE-1 go to DONE. Total SIZE cycles. src==dst without transpose is legal (no-op rewrite).
  - DONE: copy_done_o=1 for one cycle, busy_o=0, then IDLE. copy_start_i in COPY or DONE is ignored.
  - Reads during COPY are served normally and may observe a partially written dst.
- flush_i: highest priority after reset.
  - FSM to IDLE with no done pulse; dst rows already written remain.
  - All in-flight read stages invalidated; rd_valid_o = 0 from the next cycle for READ_LATENCY cycles.
  - A rd_valid_i in the flush cycle is dropped; a write in the flush cycle is still committed if wr_ready_o was high.
- Out-of-range addresses (non-power-of-two SIZE/NUM_BANKS): read returns 0; write and copy are ignored.

Optional Feature:
- Macro CMAT_STORE_CONJ_EN.
- When defined, adds inputs rd_conj_i and copy_conj_i (1 bit each). When high, every element's imaginary sign bit (bit 2*WIDTH-1 of each element) is inverted on the read output or the copy path. Combined with transpose this gives a Hermitian transpose.
- When undefined, the ports are absent and data passes unmodified.

Test Plan:
- After reset, write bank0 row1 element2 = {imag 3.0, real -1.5}; read with READ_LATENCY=2 -> rd_valid_o exactly 2 cycles later, rd_addr_o=1, element2 = {3.0, -1.5}, other elements 0.
- Write bank1 row r, element c = real (10r+c); transposed read addr 2 -> element k real = 10k+2 for k=0..3.
- copy_start src=1, dst=2, transpose=1 -> busy_o high 4 cycles, wr_ready_o=0 during COPY, copy_done_o one pulse; bank2[i][j] = bank1[j][i] for all i, j.
- copy_start src=dst=3, transpose=1 -> copy_err_o pulse, busy_o stays 0, bank3 unchanged.
- flush_i asserted on the 2nd COPY cycle with reads in flight -> FSM returns to IDLE, no copy_done_o, dst rows 0..1 updated and rows 2..3 unchanged, rd_valid_o low for READ_LATENCY cycles.
- Same-cycle read and write to bank0 row0 (old value 5.0, new value 7.0) -> read returns 5.0, a following read returns 7.0. With CMAT_STORE_CONJ_EN and rd_conj_i=1, imag 2.0 is read as -2.0.
